// File: rtl/mips_instr_sequencer.sv
// Instruction sequencer for the single-cycle R-type MIPS core: loads a program, issues it word by word
// over valid/ready and summarises the results. Define RESULT_FIFO_EN to add a 4-entry result FIFO.
module mips_instr_sequencer #(
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 64,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_we,
    input  logic [AW-1:0] i_load_addr,
    input  logic [31:0]   i_load_data,
    input  logic          i_start,
    input  logic [AW:0]   i_prog_len,
    output logic [31:0]   o_instr_out,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    input  logic [31:0]   i_core_result,
    input  logic          i_result_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [AW:0]   o_issued_cnt,
    output logic [31:0]   o_last_result,
    output logic [31:0]   o_result_xor,
    input  logic          i_fifo_pop,
    output logic [31:0]   o_fifo_data,
    output logic          o_fifo_empty,
    output logic          o_fifo_ovf
);
    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]     LEN_MAX   = (AW+1)'(DEPTH);
    localparam logic [31:0]     SYSCALL   = 32'h0000_000C;
    localparam logic [TW-1:0]   WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_len;
    logic [AW:0]   r_issued_cnt;
    logic [TW-1:0] r_wait_cnt;
    logic          r_instr_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [31:0]   r_last_result;
    logic [31:0]   r_result_xor;
    logic [31:0]   r_instr;
    logic [31:0]   r_mem [DEPTH];

    logic [AW:0]   w_len_clamped;
    logic [AW:0]   w_pc_next;
    logic          w_capture;

    assign w_len_clamped = (i_prog_len > LEN_MAX) ? LEN_MAX : i_prog_len;
    assign w_pc_next     = {1'b0, r_pc} + (AW+1)'(1);
    assign w_capture     = (r_state == S_WAIT) && i_result_valid;

    // Program memory: writes only while idle, registered read in FETCH so ISSUE sees the word.
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_load_we) begin
            r_mem[i_load_addr] <= i_load_data;
        end
        if (r_state == S_FETCH) begin
            r_instr <= r_mem[r_pc];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_len         <= '0;
            r_issued_cnt  <= '0;
            r_wait_cnt    <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_last_result <= '0;
            r_result_xor  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc          <= '0;
                        r_issued_cnt  <= '0;
                        r_last_result <= '0;
                        r_result_xor  <= '0;
                        r_error       <= 1'b0;
                        r_len         <= w_len_clamped;
                        r_busy        <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_state       <= S_ISSUE;
                    r_instr_valid <= 1'b1;
                end
                S_ISSUE: begin
                    if (i_instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_issued_cnt  <= r_issued_cnt + (AW+1)'(1);
                        r_wait_cnt    <= '0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_last_result <= i_core_result;
                        r_result_xor  <= r_result_xor ^ i_core_result;
                        r_pc          <= r_pc + AW'(1);
                        if (w_pc_next == r_len || r_instr == SYSCALL) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_instr_out   = r_instr_valid ? r_instr : '0;
    assign o_instr_valid = r_instr_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_issued_cnt  = r_issued_cnt;
    assign o_last_result = r_last_result;
    assign o_result_xor  = r_result_xor;

`ifdef RESULT_FIFO_EN
    logic [31:0] w_fifo_ent [4];
    logic [2:0]  r_fifo_wp;
    logic [2:0]  r_fifo_rp;
    logic        r_fifo_ovf;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_fifo_pop;
    logic        w_fifo_push;

    assign w_fifo_empty = (r_fifo_wp == r_fifo_rp);
    assign w_fifo_full  = ((r_fifo_wp - r_fifo_rp) == 3'd4);
    assign w_fifo_pop   = i_fifo_pop && !w_fifo_empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign w_fifo_push  = w_capture && (!w_fifo_full || w_fifo_pop);

    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo_ent
        logic [31:0] r_data;
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_data <= '0;
            end else if (w_fifo_push && (r_fifo_wp[1:0] == 2'(gi))) begin
                r_data <= i_core_result;
            end
        end
        assign w_fifo_ent[gi] = r_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fifo_wp  <= '0;
            r_fifo_rp  <= '0;
            r_fifo_ovf <= 1'b0;
        end else begin
            if (w_fifo_pop)  r_fifo_rp <= r_fifo_rp + 3'd1;
            if (w_fifo_push) r_fifo_wp <= r_fifo_wp + 3'd1;
            if (w_capture && w_fifo_full && !w_fifo_pop) r_fifo_ovf <= 1'b1;
        end
    end

    assign o_fifo_data  = w_fifo_ent[r_fifo_rp[1:0]];
    assign o_fifo_empty = w_fifo_empty;
    assign o_fifo_ovf   = r_fifo_ovf;
`else
    logic w_fifo_unused;
    assign w_fifo_unused = i_fifo_pop;
    assign o_fifo_data   = '0;
    assign o_fifo_empty  = 1'b1;
    assign o_fifo_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_instr_sequencer.sv
// Randomised bench for mips_instr_sequencer: a behavioural core and program model predict the issued
// words, result summary, timeout and done pulse for each run.
module tb_mips_instr_sequencer;
    localparam int          DEPTH   = 16;
    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_load_we;
    logic [3:0]  i_load_addr;
    logic [31:0] i_load_data;
    logic        i_start;
    logic [4:0]  i_prog_len;
    logic [31:0] o_instr_out;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] i_core_result;
    logic        i_result_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [4:0]  o_issued_cnt;
    logic [31:0] o_last_result;
    logic [31:0] o_result_xor;
    logic        i_fifo_pop;
    logic [31:0] o_fifo_data;
    logic        o_fifo_empty;
    logic        o_fifo_ovf;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] res_log [$];

    always #5 clk = ~clk;

    mips_instr_sequencer dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_load_we     (i_load_we),
        .i_load_addr   (i_load_addr),
        .i_load_data   (i_load_data),
        .i_start       (i_start),
        .i_prog_len    (i_prog_len),
        .o_instr_out   (o_instr_out),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .i_core_result (i_core_result),
        .i_result_valid(i_result_valid),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_issued_cnt  (o_issued_cnt),
        .o_last_result (o_last_result),
        .o_result_xor  (o_result_xor),
        .i_fifo_pop    (i_fifo_pop),
        .o_fifo_data   (o_fifo_data),
        .o_fifo_empty  (o_fifo_empty),
        .o_fifo_ovf    (o_fifo_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_rtype();
        logic [5:0] f;
        case ($urandom_range(3, 0))
            0:       f = 6'h20;
            1:       f = 6'h22;
            2:       f = 6'h24;
            default: f = 6'h25;
        endcase
        return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, f};
    endfunction

    task automatic load_word(input int a, input logic [31:0] d);
        @(negedge clk);
        i_load_we   = 1'b1;
        i_load_addr = 4'(a);
        i_load_data = d;
        model_mem[a] = d;
        @(negedge clk);
        i_load_we = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_instr_out",   o_instr_out, 0);
        chk("rst_instr_valid", 32'(o_instr_valid), 0);
        chk("rst_busy",        32'(o_busy), 0);
        chk("rst_done",        32'(o_done), 0);
        chk("rst_error",       32'(o_error), 0);
        chk("rst_issued_cnt",  32'(o_issued_cnt), 0);
        chk("rst_last_result", o_last_result, 0);
        chk("rst_result_xor",  o_result_xor, 0);
        chk("rst_fifo_data",   o_fifo_data, 0);
        chk("rst_fifo_empty",  32'(o_fifo_empty), 1);
        chk("rst_fifo_ovf",    32'(o_fifo_ovf), 0);
    endtask

    // One run: the core model accepts after a random hold and answers after a random delay.
    task automatic run_prog(input int len, input int hold_min, input int hold_max,
                            input int dly_max, input bit respond, input bit noise);
        logic [31:0] exp_q [$];
        logic [31:0] exp_xor, exp_last, held_word, r;
        int          clamped, n_exp, issued, hold, dly, cyc, wait_cyc, a;
        bit          in_wait, accepted, done_seen, exp_err;
        @(negedge clk);
        i_start    = 1'b1;
        i_prog_len = 5'(len);
        if (noise && $urandom_range(1, 0) == 1) begin
            a = $urandom_range(DEPTH - 1, 0);
            r = rand_rtype();
            i_load_we    = 1'b1;
            i_load_addr  = 4'(a);
            i_load_data  = r;
            model_mem[a] = r;
        end
        clamped = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < clamped; i++) begin
            exp_q.push_back(model_mem[i]);
            if (model_mem[i] == SYSCALL) break;
        end
        n_exp   = respond ? exp_q.size() : ((exp_q.size() > 0) ? 1 : 0);
        exp_err = !respond && (n_exp > 0);
        exp_xor = '0; exp_last = '0; held_word = '0;
        issued = 0; hold = -1; dly = 0; cyc = 0; wait_cyc = 0;
        in_wait = 1'b0; accepted = 1'b0; done_seen = 1'b0;
        res_log.delete();
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            i_start        = 1'b0;
            i_load_we      = 1'b0;
            i_instr_ready  = 1'b0;
            i_result_valid = 1'b0;
            i_core_result  = $urandom();
            if (accepted) begin
                chk("vld_drop", 32'(o_instr_valid), 0);
                accepted = 1'b0;
                issued++;
                in_wait = 1'b1;
                hold    = -1;
                dly     = $urandom_range(dly_max, 0);
            end
            if (o_done) begin
                done_seen = 1'b1;
                break;
            end
            if (in_wait) begin
                wait_cyc++;
                if (respond) begin
                    if (dly == 0) begin
                        r = $urandom();
                        i_result_valid = 1'b1;
                        i_core_result  = r;
                        exp_xor  ^= r;
                        exp_last  = r;
                        res_log.push_back(r);
                        in_wait   = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end else if (hold >= 0 || o_instr_valid) begin
                if (hold < 0) begin
                    if (issued < exp_q.size()) chk("instr_word", o_instr_out, exp_q[issued]);
                    else chk("issue_extra", 32'(issued + 1), 32'(exp_q.size()));
                    held_word = o_instr_out;
                    hold = $urandom_range(hold_max, hold_min);
                end else begin
                    chk("vld_stable", 32'(o_instr_valid), 1);
                    chk("instr_stable", o_instr_out, held_word);
                end
                if (hold == 0) begin
                    i_instr_ready = 1'b1;
                    accepted      = 1'b1;
                end else begin
                    hold--;
                    if (noise && $urandom_range(3, 0) == 0) i_result_valid = 1'b1;
                end
            end
            if (noise && o_busy && $urandom_range(7, 0) == 0) begin
                i_start    = 1'b1;
                i_prog_len = 5'($urandom);
            end
            if (noise && o_busy && $urandom_range(7, 0) == 0) begin
                i_load_we   = 1'b1;
                i_load_addr = 4'($urandom);
                i_load_data = $urandom();
            end
        end
        chk("run_bound", 32'(done_seen), 1);
        if (done_seen) begin
            if (clamped == 0) chk("len0_latency", 32'(cyc), 1);
            if (exp_err) chk("timeout_cycles", 32'(wait_cyc), 64);
            chk("issued_cnt",   32'(o_issued_cnt), 32'(n_exp));
            chk("issued_seen",  32'(issued), 32'(n_exp));
            chk("result_xor",   o_result_xor, exp_xor);
            chk("last_result",  o_last_result, exp_last);
            chk("error",        32'(o_error), 32'(exp_err));
            chk("busy_in_done", 32'(o_busy), 1);
            @(negedge clk);
            chk("done_one_cycle", 32'(o_done), 0);
            chk("busy_after",     32'(o_busy), 0);
            chk("error_sticky",   32'(o_error), 32'(exp_err));
        end
        $display("run len=%0d issued=%0d xor=%08h err=%0d", len, issued, o_result_xor, o_error);
    endtask

    initial begin
        int d;
        i_reset = 1'b1; i_load_we = 1'b0; i_load_addr = '0; i_load_data = '0;
        i_start = 1'b0; i_prog_len = '0; i_instr_ready = 1'b0; i_core_result = '0;
        i_result_valid = 1'b0; i_fifo_pop = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        i_reset = 1'b0;

        for (int a = 0; a < DEPTH; a++) load_word(a, rand_rtype());
        load_word(0, 32'h0022_1820);
        load_word(1, 32'h0022_1822);
        load_word(2, 32'h0022_1824);
        load_word(3, 32'h0022_1825);
        run_prog(4, 0, 0, 0, 1'b1, 1'b0);
        run_prog(4, 5, 5, 0, 1'b1, 1'b0);

        load_word(1, SYSCALL);
        run_prog(4, 0, 2, 2, 1'b1, 1'b0);
        load_word(1, rand_rtype());

        run_prog(3, 0, 1, 0, 1'b0, 1'b0);
        run_prog(2, 0, 0, 0, 1'b1, 1'b0);
        run_prog(0, 0, 0, 0, 1'b1, 1'b0);

        for (int a = 0; a < DEPTH; a++) load_word(a, rand_rtype());
        run_prog(31, 0, 1, 1, 1'b1, 1'b0);

        repeat (20) begin
            if ($urandom_range(3, 0) == 0) load_word($urandom_range(DEPTH - 1, 0), SYSCALL);
            else load_word($urandom_range(DEPTH - 1, 0), rand_rtype());
            run_prog($urandom_range(20, 0), 0, $urandom_range(4, 0), $urandom_range(4, 0), 1'b1, 1'b1);
        end

        // Abort a run with reset: everything returns to reset values and no done pulse follows.
        for (int a = 0; a < DEPTH; a++) load_word(a, rand_rtype());
        @(negedge clk);
        i_start = 1'b1; i_prog_len = 5'd8;
        @(negedge clk);
        i_start = 1'b0; i_instr_ready = 1'b1; i_result_valid = 1'b1; i_core_result = 32'h1234_5678;
        repeat (6) @(negedge clk);
        chk("busy_pre_reset", 32'(o_busy), 1);
        i_reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        i_reset = 1'b0; i_instr_ready = 1'b0; i_result_valid = 1'b0;
        d = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done) d++;
        end
        chk("no_done_after_reset", 32'(d), 0);
        chk("idle_after_reset", 32'(o_busy), 0);
        $display("reset abort done_pulses=%0d", d);

`ifdef RESULT_FIFO_EN
        for (int a = 0; a < 6; a++) load_word(a, rand_rtype());
        run_prog(6, 0, 1, 1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("fifo_not_empty", 32'(o_fifo_empty), 0);
            chk("fifo_data", o_fifo_data, res_log[k]);
            i_fifo_pop = 1'b1;
            @(negedge clk);
            i_fifo_pop = 1'b0;
        end
        chk("fifo_drained", 32'(o_fifo_empty), 1);
        chk("fifo_ovf", 32'(o_fifo_ovf), 1);
        i_fifo_pop = 1'b1;
        @(negedge clk);
        i_fifo_pop = 1'b0;
        chk("fifo_pop_empty", 32'(o_fifo_empty), 1);
        chk("fifo_ovf_sticky", 32'(o_fifo_ovf), 1);
        $display("fifo popped=4 ovf=%0d", o_fifo_ovf);
`else
        i_fifo_pop = 1'b1;
        @(negedge clk);
        i_fifo_pop = 1'b0;
        chk("nofifo_empty", 32'(o_fifo_empty), 1);
        chk("nofifo_data",  o_fifo_data, 0);
        chk("nofifo_ovf",   32'(o_fifo_ovf), 0);
        $display("fifo disabled empty=%0d", o_fifo_empty);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
